spi_freq_master: RTL and testbench

- FPGA-side SPI master transmitter: serialises one 16-bit word per request onto sclk/cs/sdo.
- It is the transmitting end of the frequency link the design already receives in lcdSPI.
- Used in two ways:
  - on-board loopback self-test of the receive path and LCD pipeline, with no MCU attached;
  - reporting a 16-bit status/frequency word back to the MCU.
- Runs entirely in the clk domain (24 MHz divided oscillator clock).

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_half_period_timer.sv | 38 +++
 rtl/spi_freq_master.sv | 138 +++++++++++++
 tb/tb_spi_freq_master.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI link definitions for the frequency transmitter and lcdSPI.
// Holds the frame width and the transmitter state encoding.
package spi_pkg;

  localparam int SPI_WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    FINISH
  } spi_tx_state_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Counts one sclk half-period in clk cycles.
// Strobes expire_o on the last cycle of each half-period.
module spi_half_period_timer #(
  parameter int CLK_DIV = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_freq_master.sv
// SPI mode-0 master transmitter: one MSB-first word per start request.
// cs frames the word high; all pins are driven straight from flops.
module spi_freq_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_WORD_W,
  parameter int CLK_DIV = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              sdo
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] ALL_BITS = BW'(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_tx_state_t state_q;
  spi_tx_state_t state_d;

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [BW-1:0]     bit_q;
  logic [BW-1:0]     bit_d;
  logic              sdo_q;
  logic              sdo_d;
  logic              sclk_q;
  logic              sclk_d;
  logic              cs_q;
  logic              cs_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  logic accept;
  logic in_frame;
  logic expire;

  assign accept   = (state_q == IDLE) && start;
  assign in_frame = (state_q == SETUP)
                 || (state_q == SCLK_HI)
                 || (state_q == SCLK_LO);

  spi_half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_d != state_q),
    .en_i     (in_frame),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_d = SETUP;
      SETUP:   if (expire) state_d = SCLK_HI;
      SCLK_HI: if (expire) state_d = SCLK_LO;
      SCLK_LO: begin
        if (expire) begin
          state_d = (bit_q == ALL_BITS) ? FINISH : SCLK_HI;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last bit is never shifted out so sdo keeps the LSB through cs hold.
  always_comb begin
    shreg_d = shreg_q;
    sdo_d   = sdo_q;
    bit_d   = bit_q;
    if (accept) begin
      shreg_d = data;
      sdo_d   = data[DATA_W-1];
      bit_d   = '0;
    end else if ((state_q == SCLK_HI) && expire) begin
      bit_d = bit_q + 1'b1;
      if (bit_q != LAST_BIT) begin
        shreg_d = shreg_q << 1;
        sdo_d   = shreg_q[DATA_W-2];
      end
    end
  end

  always_comb begin
    sclk_d = (state_d == SCLK_HI);
    cs_d   = (state_d == SETUP)
          || (state_d == SCLK_HI)
          || (state_d == SCLK_LO);
    busy_d = cs_d;
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      bit_q   <= '0;
      sdo_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      sdo_q   <= sdo_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign cs   = cs_q;
  assign sdo  = sdo_q;

endmodule

// File: tb/tb_spi_freq_master.sv
// Bench for spi_freq_master: a receiver model rebuilds each frame
// and checks it against words queued when each request is driven.
module tb_spi_freq_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1;
  logic        a_start = 1'b0;
  logic [15:0] a_data = '0;
  logic        a_busy, a_done, a_sclk, a_cs, a_sdo;
  logic        b_rst = 1'b1;
  logic        b_start = 1'b0;
  logic [15:0] b_data = '0;
  logic        b_busy, b_done, b_sclk, b_cs, b_sdo;

  int unsigned cyc = 0;
  int n_chk = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  spi_freq_master #(.DATA_W(16), .CLK_DIV(2)) u_a (
    .clk(clk), .reset(a_rst), .start(a_start), .data(a_data),
    .busy(a_busy), .done(a_done), .sclk(a_sclk), .cs(a_cs), .sdo(a_sdo)
  );

  spi_freq_master #(.DATA_W(16), .CLK_DIV(1)) u_b (
    .clk(clk), .reset(b_rst), .start(b_start), .data(b_data),
    .busy(b_busy), .done(b_done), .sclk(b_sclk), .cs(b_cs), .sdo(b_sdo)
  );

  // Receiver model for instance A (CLK_DIV=2)
  logic [15:0] a_word = '0;
  int a_len = 0, a_edges = 0, a_low = 0, a_done_n = 0;
  int unsigned a_done_cyc = 0;
  logic a_done_busy = 1'b0, a_sclk_p = 1'b0, a_cs_p = 1'b0;
  logic [15:0] a_rx_q[$];
  logic [15:0] a_exp_q[$];
  int a_len_q[$];
  int a_edge_q[$];
  int a_gap_q[$];

  always @(negedge clk) begin
    a_sclk_p <= a_sclk;
    a_cs_p   <= a_cs;
    if (a_done) begin
      a_done_n    <= a_done_n + 1;
      a_done_cyc  <= cyc;
      a_done_busy <= a_busy;
    end
    if (a_cs) begin
      a_len <= a_len + 1;
      if (a_sclk && !a_sclk_p) begin
        a_word  <= {a_word[14:0], a_sdo};
        a_edges <= a_edges + 1;
      end
    end else begin
      a_low <= a_low + 1;
    end
    if (a_cs && !a_cs_p) begin
      a_gap_q.push_back(a_low);
      a_low <= 0;
    end
    if (!a_cs && a_cs_p) begin
      a_rx_q.push_back(a_word);
      a_len_q.push_back(a_len);
      a_edge_q.push_back(a_edges);
      a_word  <= '0;
      a_len   <= 0;
      a_edges <= 0;
    end
  end

  // Receiver model for instance B (CLK_DIV=1), also tracks sclk period
  logic [15:0] b_word = '0;
  int b_len = 0, b_edges = 0;
  int unsigned b_last = 0, b_pmin = 0, b_pmax = 0;
  logic b_sclk_p = 1'b0, b_cs_p = 1'b0;
  logic [15:0] b_rx_q[$];
  logic [15:0] b_exp_q[$];
  int b_len_q[$];
  int b_edge_q[$];

  always @(negedge clk) begin
    b_sclk_p <= b_sclk;
    b_cs_p   <= b_cs;
    if (b_cs && !b_cs_p) begin
      b_pmin <= 1000;
      b_pmax <= 0;
    end
    if (b_cs) begin
      b_len <= b_len + 1;
      if (b_sclk && !b_sclk_p) begin
        b_word  <= {b_word[14:0], b_sdo};
        b_edges <= b_edges + 1;
        b_last  <= cyc;
        if (b_edges > 0) begin
          if (cyc - b_last < b_pmin) b_pmin <= cyc - b_last;
          if (cyc - b_last > b_pmax) b_pmax <= cyc - b_last;
        end
      end
    end
    if (!b_cs && b_cs_p) begin
      b_rx_q.push_back(b_word);
      b_len_q.push_back(b_len);
      b_edge_q.push_back(b_edges);
      b_word  <= '0;
      b_len   <= 0;
      b_edges <= 0;
    end
  end

  task automatic send_a(input logic [15:0] d, output int unsigned t0);
    @(negedge clk);
    t0 = cyc;
    a_data = d;
    a_start = 1'b1;
    a_exp_q.push_back(d);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a_frame(input string tag);
    int k;
    k = 0;
    while (a_rx_q.size() == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (a_rx_q.size() == 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL %s_timeout: no frame after %0d cycles, want one", tag, k);
    end
  endtask

  task automatic check_a_frame(input string tag, input int exp_len);
    logic [15:0] got, want;
    int len, edges;
    if (a_rx_q.size() == 0 || a_exp_q.size() == 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL %s_empty: rx=%0d exp=%0d queued, want both >0",
               tag, a_rx_q.size(), a_exp_q.size());
      return;
    end
    got = a_rx_q.pop_front();
    want = a_exp_q.pop_front();
    len = a_len_q.pop_front();
    edges = a_edge_q.pop_front();
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s_word: got %h want %h", tag, got, want);
    end
    n_chk++;
    if (len !== exp_len) begin
      n_bad++;
      $display("FAIL %s_cslen: got %0d want %0d", tag, len, exp_len);
    end
    n_chk++;
    if (edges !== 16) begin
      n_bad++;
      $display("FAIL %s_edges: got %0d want 16", tag, edges);
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    b_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_busy, a_done, a_sclk, a_cs, a_sdo} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_a: got %b want 00000",
               {a_busy, a_done, a_sclk, a_cs, a_sdo});
    end
    n_chk++;
    if ({b_busy, b_done, b_sclk, b_cs, b_sdo} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_b: got %b want 00000",
               {b_busy, b_done, b_sclk, b_cs, b_sdo});
    end
    a_rst = 1'b0;
    b_rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int unsigned t0;
    int n0;
    n0 = a_done_n;
    send_a(16'h00BD, t0);
    wait_a_frame("single");
    repeat (5) @(negedge clk);
    check_a_frame("single", 66);
    n_chk++;
    if (a_done_n - n0 !== 1) begin
      n_bad++;
      $display("FAIL single_done_cnt: got %0d want 1", a_done_n - n0);
    end
    n_chk++;
    if (a_done_cyc !== t0 + 67) begin
      n_bad++;
      $display("FAIL single_done_time: got %0d want %0d", a_done_cyc, t0 + 67);
    end
    n_chk++;
    if (a_done_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy_at_done: got %b want 0", a_done_busy);
    end
  endtask

  task automatic test_loopback();
    logic [15:0] words [3];
    int unsigned t0;
    int n0;
    words[0] = 16'h1234;
    words[1] = 16'hFFFF;
    words[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      n0 = a_done_n;
      send_a(words[i], t0);
      wait_a_frame("loop");
      repeat (5) @(negedge clk);
      check_a_frame("loop", 66);
      n_chk++;
      if (a_done_n - n0 !== 1) begin
        n_bad++;
        $display("FAIL loop_done_cnt[%0d]: got %0d want 1", i, a_done_n - n0);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int unsigned t0;
    int n0;
    n0 = a_done_n;
    send_a(16'h5555, t0);
    repeat (20) @(negedge clk);
    a_data = 16'hAAAA;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_a_frame("ignore");
    repeat (100) @(negedge clk);
    check_a_frame("ignore", 66);
    n_chk++;
    if (a_rx_q.size() !== 0) begin
      n_bad++;
      $display("FAIL ignore_extra_frame: got %0d frames want 0", a_rx_q.size());
    end
    n_chk++;
    if (a_done_n - n0 !== 1) begin
      n_bad++;
      $display("FAIL ignore_done_cnt: got %0d want 1", a_done_n - n0);
    end
  endtask

  task automatic test_back_to_back();
    int n0, dn, k;
    n0 = a_done_n;
    a_gap_q.delete();
    @(negedge clk);
    a_data = 16'hC3C3;
    a_start = 1'b1;
    for (int i = 0; i < 3; i++) a_exp_q.push_back(16'hC3C3);
    dn = 0;
    k = 0;
    while (dn < 3 && k < 1000) begin
      @(negedge clk);
      if (a_done) dn++;
      k++;
    end
    a_start = 1'b0;
    if (dn < 3) begin
      n_chk++;
      n_bad++;
      $display("FAIL b2b_timeout: got %0d done pulses want 3", dn);
    end
    repeat (100) @(negedge clk);
    for (int i = 0; i < 3; i++) check_a_frame("b2b", 66);
    n_chk++;
    if (a_done_n - n0 !== 3 || a_rx_q.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_count: got done=%0d extra=%0d want 3 and 0",
               a_done_n - n0, a_rx_q.size());
    end
    n_chk++;
    if (a_gap_q.size() !== 3) begin
      n_bad++;
      $display("FAIL b2b_gap_count: got %0d want 3", a_gap_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_chk++;
        if (a_gap_q[i] !== 2) begin
          n_bad++;
          $display("FAIL b2b_gap[%0d]: got %0d want 2", i, a_gap_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    int n0, e, k;
    logic prev;
    n0 = a_done_n;
    send_a(16'h00BD, t0);
    e = 0;
    k = 0;
    prev = 1'b0;
    while (e < 9 && k < 200) begin
      @(negedge clk);
      if (a_sclk && !prev) e++;
      prev = a_sclk;
      k++;
    end
    n_chk++;
    if (a_sdo !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_bit7: got %b want 1", a_sdo);
    end
    a_rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({a_cs, a_sclk, a_sdo, a_busy, a_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL rstmid_idle: got %b want 00000",
               {a_cs, a_sclk, a_sdo, a_busy, a_done});
    end
    a_rst = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++;
    if (a_done_n - n0 !== 0) begin
      n_bad++;
      $display("FAIL rstmid_done: got %0d pulses want 0", a_done_n - n0);
    end
    while (a_rx_q.size() > 0) begin
      void'(a_rx_q.pop_front());
      void'(a_len_q.pop_front());
      void'(a_edge_q.pop_front());
    end
    while (a_exp_q.size() > 0) void'(a_exp_q.pop_front());
    send_a(16'h00BD, t0);
    wait_a_frame("rstmid_after");
    repeat (5) @(negedge clk);
    check_a_frame("rstmid_after", 66);
  endtask

  task automatic test_div1();
    logic [15:0] got, want;
    int k;
    @(negedge clk);
    b_data = 16'h8001;
    b_start = 1'b1;
    b_exp_q.push_back(16'h8001);
    @(negedge clk);
    b_start = 1'b0;
    k = 0;
    while (b_rx_q.size() == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    if (b_rx_q.size() == 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL div1_timeout: no frame after %0d cycles, want one", k);
      return;
    end
    got = b_rx_q.pop_front();
    want = b_exp_q.pop_front();
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL div1_word: got %h want %h", got, want);
    end
    n_chk++;
    if (b_len_q[0] !== 33) begin
      n_bad++;
      $display("FAIL div1_cslen: got %0d want 33", b_len_q[0]);
    end
    n_chk++;
    if (b_edge_q[0] !== 16) begin
      n_bad++;
      $display("FAIL div1_edges: got %0d want 16", b_edge_q[0]);
    end
    n_chk++;
    if (b_pmin !== 2 || b_pmax !== 2) begin
      n_bad++;
      $display("FAIL div1_period: got min=%0d max=%0d want 2", b_pmin, b_pmax);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
